// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the fetch PC unit
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned ialign);
        logic [63:0] mask;
        mask = 64'(ialign) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - trap/branch redirect priority and alignment check
import fetch_pkg::*;

module pc_redirect_arb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            take,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    logic target_ok;

    // A trap always wins, so a misaligned branch on the same cycle is silently dropped.
    always_comb begin
        target_ok  = is_aligned(64'(redirect_target), IALIGN);
        take       = trap_valid | (redirect_valid & target_ok);
        target     = trap_valid ? (trap_vector & ~ALIGN_MASK) : redirect_target;
        misaligned = redirect_valid & ~trap_valid & ~target_ok;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC sequencer with single outstanding imem request
import fetch_pkg::*;

module fetch_pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            if_ready,
    output logic            misaligned
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] pend_target, pend_n;
    logic            kill, kill_n;
    logic            capture;
    logic            take, arb_misaligned;
    logic [XLEN-1:0] target;

    pc_redirect_arb #(.XLEN(XLEN), .IALIGN(IALIGN)) u_arb (
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .take            (take),
        .target          (target),
        .misaligned      (arb_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            pend_target <= '0;
            kill        <= 1'b0;
            if_pc       <= '0;
            if_instr    <= '0;
            misaligned  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_target <= pend_n;
            kill        <= kill_n;
            misaligned  <= arb_misaligned & (state != BOOT);
            if (capture) begin
                if_pc    <= pc;
                if_instr <= imem_rsp_data;
            end
        end
    end

    // A redirect that lands after the request is accepted cannot recall it; the
    // response is instead marked for discard and the target parked in pend_target.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend_target;
        kill_n  = kill;
        capture = 1'b0;
        unique case (state)
            BOOT: state_n = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_n = WAIT;
                    if (take) begin
                        kill_n = 1'b1;
                        pend_n = target;
                    end
                end else if (take) begin
                    pc_n = target;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_n = REQ;
                    kill_n  = 1'b0;
                    if (take) begin
                        pc_n = target;
                    end else if (kill) begin
                        pc_n = pend_target;
                    end else begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end
                end else if (take) begin
                    kill_n = 1'b1;
                    pend_n = target;
                end
            end
            HOLD: begin
                if (take) begin
                    pc_n    = target;
                    state_n = REQ;
                end else if (if_ready) begin
                    pc_n    = pc + XLEN'(IALIGN);
                    state_n = REQ;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == HOLD);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized bench for fetch_pc_unit against a transaction-level model
module tb_fetch_pc_unit;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RV     = 32'h0;
    localparam int          IALIGN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0, trap_valid = 1'b0;
    logic [31:0] redirect_target = '0, trap_vector = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid, if_ready = 1'b0, misaligned;
    logic [31:0] if_pc, if_instr;

    fetch_pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .IALIGN(IALIGN)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // stimulus knobs
    logic        s_redir, s_trap, s_ready, s_rsp_en, s_if_ready;
    logic [31:0] s_rtgt, s_tvec;

    // memory: one accepted request outstanding at most
    logic        mem_busy;
    logic [31:0] mem_addr;
    logic [31:0] req_log[$];
    int          ifv_count;

    // model: which transaction phase the fetch stream is in, and where it goes next
    logic        m_boot, m_out, m_held, m_squash, m_mis;
    logic [31:0] m_pc, m_out_addr, m_held_pc;

    task automatic model_reset();
        m_boot = 1'b1; m_out = 1'b0; m_held = 1'b0; m_squash = 1'b0; m_mis = 1'b0;
        m_pc = RV; m_out_addr = '0; m_held_pc = '0;
        mem_busy = 1'b0; mem_addr = '0;
    endtask

    task automatic defaults();
        s_redir = 0; s_trap = 0; s_rtgt = 0; s_tvec = 0;
        s_ready = 1; s_rsp_en = 1; s_if_ready = 1;
    endtask

    task automatic cycle();
        logic        exp_req, take, rsp;
        logic [31:0] tgt;
        exp_req = !m_boot && !m_out && !m_held;
        check("req_valid", imem_req_valid, exp_req);
        if (exp_req) check("req_addr", imem_req_addr, m_pc);
        check("if_valid", if_valid, m_held);
        if (m_held) begin
            ifv_count++;
            check("if_pc", if_pc, m_held_pc);
            check("if_instr", if_instr, word(m_held_pc));
        end
        check("misaligned", misaligned, m_mis);

        rsp = mem_busy && s_rsp_en;
        redirect_valid  = s_redir;  redirect_target = s_rtgt;
        trap_valid      = s_trap;   trap_vector     = s_tvec;
        imem_req_ready  = s_ready;  if_ready        = s_if_ready;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = rsp ? word(mem_addr) : $urandom;

        if (rsp) mem_busy = 1'b0;
        if (imem_req_valid && s_ready) begin
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            req_log.push_back(imem_req_addr);
        end

        take  = !m_boot && (s_trap || (s_redir && (s_rtgt % IALIGN) == 0));
        tgt   = s_trap ? (s_tvec - (s_tvec % IALIGN)) : s_rtgt;
        m_mis = !m_boot && s_redir && !s_trap && (s_rtgt % IALIGN) != 0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_out) begin
            if (take) m_pc = tgt;
            if (rsp) begin
                m_out = 1'b0;
                if (!take && !m_squash) begin
                    m_held = 1'b1;
                    m_held_pc = m_out_addr;
                end
                m_squash = 1'b0;
            end else if (take) begin
                m_squash = 1'b1;
            end
        end else if (m_held) begin
            if (take) begin
                m_held = 1'b0; m_pc = tgt;
            end else if (s_if_ready) begin
                m_held = 1'b0; m_pc = m_held_pc + IALIGN;
            end
        end else begin
            if (s_ready) begin
                m_out = 1'b1; m_out_addr = m_pc; m_squash = take;
            end
            if (take) m_pc = tgt;
        end
        @(negedge clk);
    endtask

    initial begin
        defaults();
        model_reset();
        ifv_count = 0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_misaligned", misaligned, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // straight-line fetch with zero-wait memory
        repeat (10) cycle();
        check("t1_nreq", req_log.size(), 3);
        if (req_log.size() >= 3) begin
            check("t1_addr0", req_log[0], 32'h0);
            check("t1_addr1", req_log[1], 32'h4);
            check("t1_addr2", req_log[2], 32'h8);
        end
        check("t1_ifv", ifv_count, 3);

        // redirect while waiting: response discarded
        cycle();
        s_rsp_en = 0; s_redir = 1; s_rtgt = 32'h100;
        cycle();
        s_redir = 0; s_rsp_en = 1;
        cycle();
        check("t2_ifv", if_valid, 0);
        check("t2_reqv", imem_req_valid, 1);
        check("t2_addr", imem_req_addr, 32'h100);

        // trap beats branch while holding an instruction
        repeat (2) cycle();
        check("t3_held", if_valid, 1);
        check("t3_held_pc", if_pc, 32'h100);
        s_trap = 1; s_tvec = 32'h82; s_redir = 1; s_rtgt = 32'h200; s_if_ready = 0;
        cycle();
        check("t3_ifv", if_valid, 0);
        check("t3_addr", imem_req_addr, 32'h80);
        defaults();

        // misaligned branch target ignored, one-cycle pulse
        s_ready = 0; s_redir = 1; s_rtgt = 32'h102;
        cycle();
        check("t4_pulse", misaligned, 1);
        check("t4_addr", imem_req_addr, 32'h80);
        s_redir = 0;
        cycle();
        check("t4_pulse_end", misaligned, 0);

        // stalled request re-presents only on redirect
        for (int i = 0; i < 5; i++) begin
            s_redir = (i == 1); s_rtgt = 32'h40;
            cycle();
            check("t5_addr", imem_req_addr, (i == 0) ? 32'h80 : 32'h40);
            check("t5_reqv", imem_req_valid, 1);
        end
        defaults();

        // asynchronous reset with a request outstanding
        cycle();
        s_rsp_en = 0;
        cycle();
        #2 reset = 1'b1;
        #1;
        check("t6_req_valid", imem_req_valid, 0);
        check("t6_if_valid", if_valid, 0);
        check("t6_if_pc", if_pc, 0);
        check("t6_if_instr", if_instr, 0);
        check("t6_misaligned", misaligned, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        defaults();
        cycle();
        check("t6_reqv", imem_req_valid, 1);
        check("t6_addr", imem_req_addr, RV);

        for (int i = 0; i < 4000; i++) begin
            s_redir    = ($urandom % 8) == 0;
            s_rtgt     = ($urandom & 32'h0000_0FFC) | ((($urandom % 4) == 0) ? 32'h2 : 32'h0);
            s_trap     = ($urandom % 16) == 0;
            s_tvec     = $urandom;
            s_ready    = ($urandom % 3) != 0;
            s_rsp_en   = ($urandom % 2) != 0;
            s_if_ready = ($urandom % 3) != 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
